// File: rtl/nios_system_pulse_out.sv
// rtl/nios_system_pulse_out.sv - Avalon-MM output PIO with hardware one-shot pulse (optional NIOS_PULSE_OUT_BITSET_EN adds OUTSET/OUTCLR)
module nios_system_pulse_out #(
    parameter int                WIDTH       = 8,
    parameter logic [WIDTH-1:0]  RESET_VALUE = '0,
    parameter int                CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_MASK   = 3'd1;
    localparam logic [2:0] ADDR_PULSE  = 3'd2;
    localparam logic [2:0] ADDR_STATUS = 3'd3;
`ifdef NIOS_PULSE_OUT_BITSET_EN
    localparam logic [2:0] ADDR_OUTSET = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR = 3'd5;
`endif

    logic [WIDTH-1:0] data_reg;
    logic [WIDTH-1:0] mask_reg;
    logic [CNT_W-1:0] count;
    logic             busy;
    logic             done;
    logic [31:0]      rd_mux;

    logic             wr_en;
    logic [CNT_W-1:0] pulse_n;
    logic             pulse_load;
    logic             pulse_end;

    assign wr_en      = chipselect && !write_n;
    assign pulse_n    = writedata[CNT_W-1:0];
    assign pulse_load = wr_en && (address == ADDR_PULSE) && (pulse_n != '0);
    // A reload on the final edge keeps the pulse alive, so it suppresses done.
    assign pulse_end  = busy && (count == CNT_W'(1)) && !pulse_load;

    // Write bits above WIDTH/CNT_W are intentionally ignored.
    logic unused_wd;
    assign unused_wd = ^writedata;

    // DATA register: direct writes, plus optional bit set/clear aliases
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_reg <= RESET_VALUE;
        end else if (wr_en && address == ADDR_DATA) begin
            data_reg <= writedata[WIDTH-1:0];
`ifdef NIOS_PULSE_OUT_BITSET_EN
        end else if (wr_en && address == ADDR_OUTSET) begin
            data_reg <= data_reg | writedata[WIDTH-1:0];
        end else if (wr_en && address == ADDR_OUTCLR) begin
            data_reg <= data_reg & ~writedata[WIDTH-1:0];
`endif
        end
    end

    // MASK register: selects which bits flip while a pulse runs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mask_reg <= '0;
        end else if (wr_en && address == ADDR_MASK) begin
            mask_reg <= writedata[WIDTH-1:0];
        end
    end

    // Pulse counter: load (or retrigger) on nonzero write, count down to zero
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
            busy  <= 1'b0;
        end else if (pulse_load) begin
            count <= pulse_n;
            busy  <= 1'b1;
        end else if (busy) begin
            count <= count - CNT_W'(1);
            if (count == CNT_W'(1)) begin
                busy <= 1'b0;
            end
        end
    end

    // Done flag: set at natural pulse end, cleared by software; set wins
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            done <= 1'b0;
        end else if (pulse_end) begin
            done <= 1'b1;
        end else if (wr_en && address == ADDR_STATUS && writedata[1]) begin
            done <= 1'b0;
        end
    end

    // Read mux of current (pre-write) register values
    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA:   rd_mux = 32'(data_reg);
            ADDR_MASK:   rd_mux = 32'(mask_reg);
            ADDR_PULSE:  rd_mux = 32'(count);
            ADDR_STATUS: rd_mux = {30'b0, done, busy};
            default:     rd_mux = '0;
        endcase
    end

    // Registered read data, loaded every cycle independent of chipselect
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= rd_mux;
        end
    end

    assign out_port = data_reg ^ (mask_reg & {WIDTH{busy}});

endmodule

// File: tb/tb_nios_system_pulse_out.sv
// tb/tb_nios_system_pulse_out.sv - self-checking bench for nios_system_pulse_out
module tb_nios_system_pulse_out;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = 3'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic [7:0]  out_port;

    nios_system_pulse_out #(
        .WIDTH(8),
        .RESET_VALUE(8'hA5),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .readdata(readdata),
        .out_port(out_port)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    // Behavioural model: the pulse is an absolute end time, busy while edge index < m_end.
    longint ecount = 0;
    longint m_end = 0;
    logic [7:0]  m_data = 8'hA5;
    logic [7:0]  m_mask = 8'h00;
    bit          m_done = 1'b0;
    logic [31:0] m_rd = 32'd0;

    function automatic logic [7:0] m_out();
        return (ecount < m_end) ? (m_data ^ m_mask) : m_data;
    endfunction

    task automatic model_step();
        longint en = ecount + 1;
        bit bp = (ecount < m_end);
        longint rem = bp ? (m_end - ecount) : 0;
        bit wr = chipselect && !write_n;
        bit endnow = bp && (m_end == en);
        bit reload = wr && (address == 3'd2) && (writedata[15:0] != 16'd0);
        case (address)
            3'd0: m_rd = {24'd0, m_data};
            3'd1: m_rd = {24'd0, m_mask};
            3'd2: m_rd = 32'(rem);
            3'd3: m_rd = {30'd0, m_done, bp};
            default: m_rd = 32'd0;
        endcase
        if (!reset_n) begin
            m_data = 8'hA5; m_mask = 8'h00; m_end = 0; m_done = 1'b0; m_rd = 32'd0;
        end else begin
            if (wr) begin
                case (address)
                    3'd0: m_data = writedata[7:0];
                    3'd1: m_mask = writedata[7:0];
                    3'd2: if (reload) m_end = en + longint'(writedata[15:0]);
                    3'd3: if (writedata[1]) m_done = 1'b0;
`ifdef NIOS_PULSE_OUT_BITSET_EN
                    3'd4: m_data = m_data | writedata[7:0];
                    3'd5: m_data = m_data & ~writedata[7:0];
`endif
                    default: ;
                endcase
            end
            if (endnow && !reload) m_done = 1'b1;
        end
        ecount = en;
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle(input logic [2:0] a);
        chipselect = 1'b0; write_n = 1'b1; address = a;
        tick();
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        tick();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("out_port", longint'(out_port), longint'(m_out()));
            chk("readdata", longint'(readdata), longint'(m_rd));
        end
    end

    int n;

    initial begin
        // Reset
        reset_n = 1'b0;
        idle(3'd3);
        idle(3'd3);
        chk_en = 1'b1;
        chk("reset_out", out_port, 8'hA5);
        chk("reset_rd", readdata, 0);
        reset_n = 1'b1;
        idle(3'd3);
        chk("reset_status", readdata, 0);

        // Basic pulse
        wr(3'd0, 32'hFFFF_FF0F);
        wr(3'd1, 32'h0000_0081);
        wr(3'd2, 32'd5);
        address = 3'd3;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_port == 8'h8E) n++;
            if (i == 2) chk("status_busy", readdata, 1);
            idle(3'd3);
        end
        chk("basic_pulse_len", n, 5);
        chk("basic_after_out", out_port, 8'h0F);
        chk("status_done", readdata, 2);
        wr(3'd3, 32'd2);
        idle(3'd3);
        chk("status_cleared", readdata, 0);

        // Retrigger: 4 cycles of the 10, then 3 more
        n = 0;
        wr(3'd2, 32'd10);
        if (out_port != 8'h0F) n++;
        for (int i = 0; i < 3; i++) begin
            idle(3'd3);
            if (out_port != 8'h0F) n++;
        end
        wr(3'd2, 32'd3);
        if (out_port != 8'h0F) n++;
        for (int i = 0; i < 8; i++) begin
            idle(3'd3);
            if (out_port != 8'h0F) n++;
        end
        chk("retrigger_len", n, 7);
        chk("retrigger_done", readdata, 2);
        wr(3'd3, 32'd2);

        // Zero-length write is ignored
        wr(3'd2, 32'hABCD_0000);
        chk("zero_len_out", out_port, 8'h0F);
        idle(3'd3);
        chk("zero_len_status", readdata, 0);

        // Done set collides with clear: set wins
        wr(3'd2, 32'd2);
        idle(3'd3);
        wr(3'd3, 32'd2);
        idle(3'd3);
        chk("collide_clear", readdata, 2);
        wr(3'd3, 32'd2);

        // Reload on the final edge extends the pulse
        wr(3'd2, 32'd2);
        idle(3'd3);
        wr(3'd2, 32'd2);
        chk("reload_edge0", out_port, 8'h8E);
        idle(3'd3);
        chk("reload_edge1", out_port, 8'h8E);
        chk("reload_nodone", readdata, 1);
        idle(3'd3);
        chk("reload_end", out_port, 8'h0F);
        idle(3'd3);
        chk("reload_done", readdata, 2);

        // Read during write returns the old value
        address = 3'd0;
        wr(3'd0, 32'h55);
        chk("rd_during_wr", readdata, 8'h0F);
        idle(3'd0);
        chk("rd_after_wr", readdata, 8'h55);

        // Bit set/clear aliases
        wr(3'd0, 32'h30);
        wr(3'd4, 32'h03);
        wr(3'd5, 32'h10);
        idle(3'd0);
`ifdef NIOS_PULSE_OUT_BITSET_EN
        chk("bitset_data", readdata, 8'h23);
`else
        chk("bitset_data", readdata, 8'h30);
`endif
        idle(3'd4);
        chk("rd_addr4", readdata, 0);
        idle(3'd5);
        chk("rd_addr5", readdata, 0);

        // Reset mid-pulse
        wr(3'd3, 32'd2);
        wr(3'd1, 32'hFF);
        wr(3'd2, 32'd20);
        for (int i = 0; i < 6; i++) idle(3'd3);
        reset_n = 1'b0;
        idle(3'd3);
        reset_n = 1'b1;
        chk("midreset_out", out_port, 8'hA5);
        idle(3'd3);
        chk("midreset_status", readdata, 0);
        idle(3'd2);
        chk("midreset_count", readdata, 0);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            reset_n    = ($urandom_range(0, 299) != 0);
            chipselect = $urandom_range(0, 1);
            write_n    = ($urandom_range(0, 2) == 0);
            address    = 3'($urandom_range(0, 7));
            if (address == 3'd2)
                writedata = 32'($urandom_range(0, 14)) | (($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFF_0000) : 32'd0);
            else
                writedata = $urandom;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
